// File: rtl/stream_sig_collector.sv
// N-channel output reduction and run-signature collector: folds ap_fifo stream words through a
// registered XOR tree to a narrow pin pair and reports a signature and word count per kernel run.
module stream_sig_collector #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FOLD_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 4,
  parameter int unsigned SIG_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic                           ap_start,
  input  logic                           ap_done,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_din,
  input  logic [CHANNELS-1:0]            ch_write,
  output logic [CHANNELS-1:0]            ch_full_n,
  output logic [OUT_WIDTH-1:0]           data_out,
  output logic                           data_valid,
  output logic [SIG_WIDTH-1:0]           sig_out,
  output logic [CNT_WIDTH-1:0]           sig_count,
  output logic                           sig_valid,
  output logic                           overflow
);

  localparam int unsigned Levels   = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int unsigned Latency  = 2 + Levels;
  localparam int unsigned SumWidth = CNT_WIDTH + $clog2(CHANNELS + 1);

  function automatic int unsigned nodes_at(int unsigned lvl);
    return (CHANNELS + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // All tree levels live in one flat vector; level 0 is the S1 fold stage.
  function automatic int unsigned offset_at(int unsigned lvl);
    int unsigned sum;
    sum = 0;
    for (int unsigned k = 0; k < lvl; k++) sum += nodes_at(k);
    return sum;
  endfunction

  function automatic logic [FOLD_WIDTH-1:0] fold_word(logic [DATA_WIDTH-1:0] w);
    logic [FOLD_WIDTH-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / FOLD_WIDTH; i++) acc ^= w[i*FOLD_WIDTH +: FOLD_WIDTH];
    return acc;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] fold_out(logic [FOLD_WIDTH-1:0] w);
    logic [OUT_WIDTH-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FOLD_WIDTH / OUT_WIDTH; i++) acc ^= w[i*OUT_WIDTH +: OUT_WIDTH];
    return acc;
  endfunction

  localparam int unsigned Nodes = offset_at(Levels + 1);
  localparam int unsigned Root  = offset_at(Levels);

  typedef enum logic [0:0] {StIdle, StRun} run_state_e;

  logic [Nodes*FOLD_WIDTH-1:0] tree_val_d, tree_val_q;
  logic [Nodes-1:0]            tree_vld_d, tree_vld_q;
  logic [FOLD_WIDTH-1:0]       root_val;
  logic                        root_vld;
  logic [OUT_WIDTH-1:0]        data_out_q;
  logic                        data_valid_q;
  logic [Latency-1:0]          done_pipe_q;
  logic                        done_d;
  run_state_e                  state_q, state_d;
  logic                        run_start, run_end;
  logic [SIG_WIDTH-1:0]        sig_acc_q, sig_out_q;
  logic [CNT_WIDTH-1:0]        cnt_acc_q, cnt_acc_d, sig_count_q;
  logic                        ovf_acc_q, ovf_acc_d, overflow_q, sig_valid_q;
  logic [SumWidth-1:0]         cnt_sum;

  always_comb begin
    int unsigned src;
    logic [FOLD_WIDTH-1:0] node;
    logic rgt;
    tree_val_d = '0;
    tree_vld_d = '0;
    src = 0;
    node = '0;
    rgt = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      tree_val_d[c*FOLD_WIDTH +: FOLD_WIDTH] = fold_word(ch_din[c*DATA_WIDTH +: DATA_WIDTH]);
      tree_vld_d[c] = ch_write[c];
    end
    for (int unsigned lvl = 1; lvl <= Levels; lvl++) begin
      for (int unsigned n = 0; n < nodes_at(lvl); n++) begin
        src = offset_at(lvl - 1) + 2 * n;
        // An odd last child has no right sibling and is passed through.
        rgt = (2 * n + 1 < nodes_at(lvl - 1)) && tree_vld_q[src + 1];
        node = tree_vld_q[src] ? tree_val_q[src*FOLD_WIDTH +: FOLD_WIDTH] : '0;
        if (rgt) node ^= tree_val_q[(src + 1)*FOLD_WIDTH +: FOLD_WIDTH];
        tree_val_d[(offset_at(lvl) + n)*FOLD_WIDTH +: FOLD_WIDTH] = node;
        tree_vld_d[offset_at(lvl) + n] = tree_vld_q[src] | rgt;
      end
    end
  end

  assign root_val = tree_val_q[Root*FOLD_WIDTH +: FOLD_WIDTH];
  assign root_vld = tree_vld_q[Root];
  assign done_d   = done_pipe_q[Latency-1];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tree_val_q   <= '0;
      tree_vld_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_pipe_q  <= '0;
    end else begin
      tree_val_q   <= tree_val_d;
      tree_vld_q   <= tree_vld_d;
      data_out_q   <= root_vld ? fold_out(root_val) : '0;
      data_valid_q <= root_vld;
      done_pipe_q  <= {done_pipe_q[Latency-2:0], ap_done};
    end
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    run_end   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d   = StRun;
          run_start = 1'b1;
        end
      end
      StRun: begin
        if (done_d) begin
          state_d = StIdle;
          run_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Count writes as they leave S1 so the count lines up with the delayed done.
  always_comb begin
    cnt_sum = SumWidth'(cnt_acc_q);
    for (int unsigned c = 0; c < CHANNELS; c++) cnt_sum = cnt_sum + SumWidth'(tree_vld_q[c]);
    if (cnt_sum > SumWidth'({CNT_WIDTH{1'b1}})) begin
      cnt_acc_d = '1;
      ovf_acc_d = 1'b1;
    end else begin
      cnt_acc_d = cnt_sum[CNT_WIDTH-1:0];
      ovf_acc_d = ovf_acc_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      sig_acc_q   <= '0;
      cnt_acc_q   <= '0;
      ovf_acc_q   <= 1'b0;
      sig_out_q   <= '0;
      sig_count_q <= '0;
      overflow_q  <= 1'b0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_valid_q <= run_end;
      if (run_start) begin
        sig_acc_q <= '0;
        cnt_acc_q <= '0;
        ovf_acc_q <= 1'b0;
      end else if (state_q == StRun) begin
        if (root_vld) begin
          sig_acc_q <= {sig_acc_q[SIG_WIDTH-2:0], sig_acc_q[SIG_WIDTH-1]} ^ SIG_WIDTH'(root_val);
        end
        cnt_acc_q <= cnt_acc_d;
        ovf_acc_q <= ovf_acc_d;
      end
      if (run_end) begin
        sig_out_q   <= sig_acc_q;
        sig_count_q <= cnt_acc_q;
        overflow_q  <= ovf_acc_q;
      end
    end
  end

  assign ch_full_n  = '1;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sig_out    = sig_out_q;
  assign sig_count  = sig_count_q;
  assign sig_valid  = sig_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stream_sig_collector.sv
// Bench for stream_sig_collector (2 channels, 4-bit count): scoreboard of expected data beats
// and run reports, pushed at stimulus time and compared when the DUT produces them.
module tb_stream_sig_collector;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic [63:0] ch_din;
  logic [1:0]  ch_write;
  logic [1:0]  ch_full_n;
  logic [3:0]  data_out;
  logic        data_valid;
  logic [31:0] sig_out;
  logic [3:0]  sig_count;
  logic        sig_valid;
  logic        overflow;

  stream_sig_collector #(
    .CHANNELS  (2),
    .DATA_WIDTH(32),
    .FOLD_WIDTH(8),
    .OUT_WIDTH (4),
    .SIG_WIDTH (32),
    .CNT_WIDTH (4)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ch_din    (ch_din),
    .ch_write  (ch_write),
    .ch_full_n (ch_full_n),
    .data_out  (data_out),
    .data_valid(data_valid),
    .sig_out   (sig_out),
    .sig_count (sig_count),
    .sig_valid (sig_valid),
    .overflow  (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w0;
    logic        v0;
    logic [31:0] w1;
    logic        v1;
    logic        start;
    logic        done;
    logic        rst;
  } stim_t;

  typedef struct {
    int         due;
    logic [3:0] dout;
  } beat_t;

  typedef struct {
    int          due;
    logic [31:0] sig;
    logic [3:0]  cnt;
    logic        ovf;
  } report_t;

  stim_t   stim[$];
  beat_t   beat_q[$];
  report_t rep_q[$];

  logic        run_m;
  logic [31:0] sig_m;
  logic [3:0]  cnt_m;
  logic        ovf_m;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] fold_w(input logic [31:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) r = r ^ w[8*i +: 8];
    return r;
  endfunction

  function automatic void add(input logic [31:0] w0, input logic v0, input logic [31:0] w1,
                              input logic v1, input logic start, input logic done,
                              input logic rst);
    stim_t s;
    s.w0 = w0;
    s.v0 = v0;
    s.w1 = w1;
    s.v1 = v1;
    s.start = start;
    s.done = done;
    s.rst = rst;
    stim.push_back(s);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void wr(input logic [31:0] w0, input logic v0, input logic [31:0] w1,
                             input logic v1);
    add(w0, v0, w1, v1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void start_run();
    add(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void end_run();
    add(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Drives the queued stimulus, updates the reference model and scores every cycle.
  task automatic play();
    stim_t s;
    logic [7:0] root;
    int n;
    int cs;
    n = stim.size() + 8;
    for (int i = 0; i < n; i++) begin
      if (i < stim.size()) s = stim[i];
      else begin
        s.w0 = '0; s.v0 = 1'b0; s.w1 = '0; s.v1 = 1'b0;
        s.start = 1'b0; s.done = 1'b0; s.rst = 1'b0;
      end
      @(posedge ap_clk);
      #1;
      ap_rst   = s.rst;
      ap_start = s.start;
      ap_done  = s.done;
      ch_din   = {s.w1, s.w0};
      ch_write = {s.v1, s.v0};
      if (s.rst) begin
        while (beat_q.size() > 0 && beat_q[$].due > cyc) void'(beat_q.pop_back());
        while (rep_q.size() > 0 && rep_q[$].due > cyc) void'(rep_q.pop_back());
        run_m = 1'b0;
      end else begin
        if (s.start && !run_m) begin
          run_m = 1'b1;
          sig_m = 32'h0;
          cnt_m = 4'h0;
          ovf_m = 1'b0;
        end
        if (s.v0 || s.v1) begin
          root = (s.v0 ? fold_w(s.w0) : 8'h00) ^ (s.v1 ? fold_w(s.w1) : 8'h00);
          beat_q.push_back('{cyc + 3, root[7:4] ^ root[3:0]});
          if (run_m) begin
            sig_m = {sig_m[30:0], sig_m[31]} ^ {24'h0, root};
            cs = int'(cnt_m) + int'(s.v0) + int'(s.v1);
            if (cs > 15) begin
              cnt_m = 4'hF;
              ovf_m = 1'b1;
            end else cnt_m = cs[3:0];
          end
        end
        if (s.done && run_m) begin
          rep_q.push_back('{cyc + 4, sig_m, cnt_m, ovf_m});
          run_m = 1'b0;
        end
      end
      @(negedge ap_clk);
      vectors++;
      if (beat_q.size() > 0 && beat_q[0].due == cyc) begin
        if (data_valid !== 1'b1 || data_out !== beat_q[0].dout) begin
          miscompares++;
          $display("FAIL data_beat cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   cyc, data_valid, data_out, beat_q[0].dout);
        end
        void'(beat_q.pop_front());
      end else if (data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL data_idle cyc=%0d got valid=%b want valid=0", cyc, data_valid);
      end
      vectors++;
      if (rep_q.size() > 0 && rep_q[0].due == cyc) begin
        if (sig_valid !== 1'b1 || sig_out !== rep_q[0].sig || sig_count !== rep_q[0].cnt ||
            overflow !== rep_q[0].ovf) begin
          miscompares++;
          $display("FAIL run_report cyc=%0d got v=%b sig=%h cnt=%h ovf=%b want v=1 sig=%h cnt=%h ovf=%b",
                   cyc, sig_valid, sig_out, sig_count, overflow,
                   rep_q[0].sig, rep_q[0].cnt, rep_q[0].ovf);
        end
        void'(rep_q.pop_front());
      end else if (sig_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sig_idle cyc=%0d got sig_valid=%b want 0", cyc, sig_valid);
      end
    end
    stim.delete();
    vectors++;
    if (beat_q.size() != 0 || rep_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got beats=%0d reports=%0d pending want 0 0",
               beat_q.size(), rep_q.size());
      beat_q.delete();
      rep_q.delete();
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b0; ap_done = 1'b0; ch_din = '0; ch_write = '0;
    run_m = 1'b0; sig_m = '0; cnt_m = '0; ovf_m = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    vectors++;
    if ({data_valid, data_out, sig_valid, sig_out, sig_count, overflow} !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got dv=%b do=%h sv=%b so=%h sc=%h ovf=%b want all 0",
               data_valid, data_out, sig_valid, sig_out, sig_count, overflow);
    end
    vectors++;
    if (ch_full_n !== 2'b11) begin
      miscompares++;
      $display("FAIL full_n got %b want 11", ch_full_n);
    end
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  task automatic test_single();
    idle(2);
    wr(32'h12345678, 1'b1, 32'h0, 1'b0);
    idle(4);
    wr(32'h12345678, 1'b1, 32'h000000FF, 1'b1);
    idle(4);
    wr(32'h0, 1'b0, 32'h000000FF, 1'b1);
    play();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      wr($urandom(), 1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)));
    end
    play();
  endtask

  task automatic test_run_signature();
    idle(2);
    start_run();
    idle(1);
    wr(32'h12345678, 1'b1, 32'h0, 1'b0);
    wr(32'h12345678, 1'b1, 32'h0, 1'b0);
    idle(2);
    end_run();
    idle(6);
    play();
    vectors++;
    if (sig_out !== 32'h00000018 || sig_count !== 4'd2 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_signature got sig=%h cnt=%h ovf=%b want 00000018 2 0",
               sig_out, sig_count, overflow);
    end
  endtask

  task automatic test_drain();
    idle(2);
    start_run();
    idle(1);
    wr(32'hDEADBEEF, 1'b1, 32'h01020304, 1'b1);
    wr(32'h0, 1'b0, 32'h000000F0, 1'b1);
    end_run();
    idle(6);
    play();
    vectors++;
    if (sig_out !== 32'h000000BC || sig_count !== 4'd3) begin
      miscompares++;
      $display("FAIL t5_drain got sig=%h cnt=%h want 000000bc 3", sig_out, sig_count);
    end
  endtask

  task automatic test_start_done_overlap();
    idle(2);
    start_run();
    idle(1);
    wr(32'h12345678, 1'b1, 32'h0, 1'b0);
    idle(1);
    end_run();
    idle(2);
    start_run();
    start_run();
    idle(1);
    wr(32'h000000FF, 1'b1, 32'h0, 1'b0);
    idle(1);
    end_run();
    idle(6);
    play();
    vectors++;
    if (sig_out !== 32'h000000FF || sig_count !== 4'd1) begin
      miscompares++;
      $display("FAIL overlap_second_run got sig=%h cnt=%h want 000000ff 1", sig_out, sig_count);
    end
  endtask

  task automatic test_saturation();
    idle(2);
    start_run();
    idle(1);
    for (int i = 0; i < 8; i++) wr(32'h11111111 * (i + 1), 1'b1, 32'h0F0F0000 + i, 1'b1);
    wr(32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
    idle(1);
    end_run();
    idle(5);
    play();
    vectors++;
    if (sig_count !== 4'hF || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_saturate got cnt=%h ovf=%b want f 1", sig_count, overflow);
    end
    idle(2);
    start_run();
    idle(1);
    wr(32'h0, 1'b0, 32'h55AA33CC, 1'b1);
    idle(1);
    end_run();
    idle(5);
    play();
    vectors++;
    if (sig_count !== 4'd1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_next_run got cnt=%h ovf=%b want 1 0", sig_count, overflow);
    end
  endtask

  task automatic test_reset_mid_run();
    idle(2);
    start_run();
    idle(1);
    for (int i = 0; i < 5; i++) wr(32'hA0000001 + i, 1'b1, 32'h0, 1'b0);
    add(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    end_run();
    idle(6);
    play();
    vectors++;
    if ({data_valid, data_out, sig_valid, sig_out, sig_count, overflow} !== 43'h0) begin
      miscompares++;
      $display("FAIL t6_outputs got dv=%b do=%h sv=%b so=%h sc=%h ovf=%b want all 0",
               data_valid, data_out, sig_valid, sig_out, sig_count, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_run_signature();
    test_drain();
    test_start_done_overlap();
    test_saturation();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
